// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared sizing helpers for the FWFT FIFO controller.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DEPTH      = 1 << DEF_ADDR_WIDTH;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Count spans 0..DEPTH+1, so one bit beyond the address width suffices.
    function automatic int cnt_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ptr
// Description : Wrapping pointer, one extra wrap bit, sync clear and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ptr #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  inc_i,
    output logic [ADDR_WIDTH:0]   ptr_o
);

    logic [ADDR_WIDTH:0] ptr_q;
    logic [ADDR_WIDTH:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule
`default_nettype wire

// File: rtl/fifo_fwft_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_fwft_ctrl
// Description : FWFT FIFO controller driving a registered-output dual-port RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_fwft_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int AFULL_THRESH = (1 << ADDR_WIDTH) - 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_WIDTH-1:0]         s_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic [ADDR_WIDTH:0]           count,
    output logic                          almost_full,
    output logic [ADDR_WIDTH-1:0]         ram_waddr,
    output logic                          ram_we,
    output logic [DATA_WIDTH-1:0]         ram_din,
    output logic [ADDR_WIDTH-1:0]         ram_raddr,
    output logic                          ram_re,
    input  logic [DATA_WIDTH-1:0]         ram_dout
);

    localparam int CW    = cnt_width(ADDR_WIDTH);
    localparam int DEPTH = depth_of(ADDR_WIDTH);

    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_THRESH);

    logic [ADDR_WIDTH:0] wptr;
    logic [ADDR_WIDTH:0] rptr;
    logic [CW-1:0]       ram_cnt;
    logic                ram_full;
    logic                ram_empty;
    logic                push;
    logic                rd_en;
    logic                m_valid_q;
    logic                m_valid_d;

    assign ram_cnt   = wptr - rptr;
    assign ram_full  = (ram_cnt == FULL_CNT);
    assign ram_empty = (ram_cnt == '0);

    // Handshakes are gated by rst_n so nothing is written or read mid-reset.
    assign s_ready = rst_n && !ram_full && !flush;
    assign push    = s_valid && s_ready;
    assign rd_en   = rst_n && !ram_empty && (!m_valid_q || m_ready) && !flush;

    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (flush),
        .inc_i (push),
        .ptr_o (wptr)
    );

    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (flush),
        .inc_i (rd_en),
        .ptr_o (rptr)
    );

    always_comb begin
        m_valid_d = rd_en || (m_valid_q && !m_ready);
        if (flush) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
        end
    end

    assign m_valid     = m_valid_q;
    assign m_data      = ram_dout;
    assign count       = ram_cnt + {{(CW-1){1'b0}}, m_valid_q};
    assign almost_full = (count >= AFULL_CNT);

    assign ram_we    = push;
    assign ram_din   = s_data;
    assign ram_waddr = wptr[ADDR_WIDTH-1:0];
    assign ram_re    = rd_en;
    assign ram_raddr = rptr[ADDR_WIDTH-1:0];

endmodule
`default_nettype wire

// File: tb/tb_fifo_fwft_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_fwft_ctrl
// Description : Self-checking bench for fifo_fwft_ctrl with a behavioural RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_fwft_ctrl;

    localparam int AW = 2;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int AF = 3;

    logic          clk = 1'b0;
    logic          rst_n, flush, s_valid, s_ready, m_valid, m_ready;
    logic [DW-1:0] s_data, m_data, ram_din, ram_dout;
    logic [AW:0]   count;
    logic          almost_full, ram_we, ram_re;
    logic [AW-1:0] ram_waddr, ram_raddr;

    always #5 clk = ~clk;

    fifo_fwft_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AFULL_THRESH(AF)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .count       (count),
        .almost_full (almost_full),
        .ram_waddr   (ram_waddr),
        .ram_we      (ram_we),
        .ram_din     (ram_din),
        .ram_raddr   (ram_raddr),
        .ram_re      (ram_re),
        .ram_dout    (ram_dout)
    );

    // Simple dual-port RAM with registered read, as the controller expects.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_din;
        if (ram_re) ram_dout <= mem[ram_raddr];
    end

    int errors = 0;
    int checks = 0;

    // Scoreboard: every word held by the FIFO, head first.
    logic [DW-1:0] sb[$];
    logic [DW-1:0] outlog[$];
    bit            mv_m;
    logic [AW:0]   mw_p, mr_p;
    bit            e_we_m, e_re_m, pop_m, cur_rn, cur_fl, cur_mr;
    logic [DW-1:0] cur_sd;
    bit            seen77 = 1'b0;

    always @(negedge clk) if (m_valid === 1'b1 && m_data === 32'h77) seen77 = 1'b1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        mv_m = 1'b0;
        mw_p = '0;
        mr_p = '0;
    endtask

    // Drive one cycle of inputs and compare every output against the model.
    task automatic apply(input bit sv, input logic [DW-1:0] sd, input bit mr, input bit fl, input bit rn);
        int  rc;
        bit  e_sr;
        s_valid = sv; s_data = sd; m_ready = mr; flush = fl; rst_n = rn;
        #4;
        rc     = sb.size() - int'(mv_m);
        e_sr   = rn && (rc < DEPTH) && !fl;
        e_re_m = rn && (rc > 0) && (!mv_m || mr) && !fl;
        e_we_m = sv && e_sr;
        pop_m  = rn && !fl && mv_m && mr;
        cur_rn = rn; cur_fl = fl; cur_mr = mr; cur_sd = sd;
        check("s_ready", DW'(s_ready), DW'(e_sr));
        check("ram_we", DW'(ram_we), DW'(e_we_m));
        check("ram_re", DW'(ram_re), DW'(e_re_m));
        check("m_valid", DW'(m_valid), DW'(mv_m));
        check("count", DW'(count), DW'(sb.size()));
        check("almost_full", DW'(almost_full), DW'(sb.size() >= AF));
        if (e_we_m) check("ram_waddr", DW'(ram_waddr), DW'(mw_p[AW-1:0]));
        if (e_re_m) check("ram_raddr", DW'(ram_raddr), DW'(mr_p[AW-1:0]));
        if (mv_m) check("m_data", m_data, sb[0]);
    endtask

    task automatic advance();
        if (!cur_rn || cur_fl) begin
            model_reset();
        end else begin
            if (pop_m) outlog.push_back(sb.pop_front());
            if (e_we_m) begin
                sb.push_back(cur_sd);
                mw_p = mw_p + 1'b1;
            end
            if (e_re_m) mr_p = mr_p + 1'b1;
            mv_m = e_re_m || (mv_m && !cur_mr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input bit sv, input logic [DW-1:0] sd, input bit mr, input bit fl, input bit rn);
        apply(sv, sd, mr, fl, rn);
        advance();
    endtask

    typedef struct {
        bit            sv;
        logic [DW-1:0] sd;
        bit            mr;
        bit            e_sr, e_we, e_re, e_mv;
        int            e_cnt;
    } vec_t;

    vec_t vt[6];

    initial begin
        int acc;
        // Idle after reset, then a single push of 0xA5 walking through the output stage.
        vt[0] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        vt[1] = '{1'b1, 32'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        vt[2] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        vt[3] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        vt[4] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        vt[5] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};

        rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        for (int i = 0; i < 6; i++) begin
            apply(vt[i].sv, vt[i].sd, vt[i].mr, 1'b0, 1'b1);
            check($sformatf("vec%0d_s_ready", i), DW'(s_ready), DW'(vt[i].e_sr));
            check($sformatf("vec%0d_ram_we", i), DW'(ram_we), DW'(vt[i].e_we));
            check($sformatf("vec%0d_ram_re", i), DW'(ram_re), DW'(vt[i].e_re));
            check($sformatf("vec%0d_m_valid", i), DW'(m_valid), DW'(vt[i].e_mv));
            check($sformatf("vec%0d_count", i), DW'(count), DW'(vt[i].e_cnt));
            if (vt[i].e_mv) check($sformatf("vec%0d_m_data", i), m_data, 32'hA5);
            advance();
        end

        // Fill against a stalled consumer: 4 in RAM plus 1 at the output.
        acc = 0;
        for (int i = 0; i < 7; i++) begin
            apply(1'b1, DW'(i), 1'b0, 1'b0, 1'b1);
            if (s_ready === 1'b1) acc++;
            advance();
        end
        check("fill_accepted", DW'(acc), 32'd5);
        apply(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("fill_count", DW'(count), 32'd5);
        check("fill_s_ready", DW'(s_ready), 32'd0);
        check("fill_almost_full", DW'(almost_full), 32'd1);
        advance();
        outlog.delete();
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check("drain_len", DW'(outlog.size()), 32'd5);
        for (int i = 0; i < outlog.size(); i++) check($sformatf("drain_word%0d", i), outlog[i], DW'(i));
        apply(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("drain_count", DW'(count), 32'd0);
        advance();

        // Streaming: pointers wrap several times.
        outlog.delete();
        for (int i = 0; i < 16; i++) cycle(1'b1, DW'(i), 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check("stream_len", DW'(outlog.size()), 32'd16);
        for (int i = 0; i < outlog.size(); i++) check($sformatf("stream_word%0d", i), outlog[i], DW'(i));

        // Flush with three words held and a word offered on the flush cycle.
        for (int i = 0; i < 3; i++) cycle(1'b1, DW'(32'h10 + i), 1'b0, 1'b0, 1'b1);
        apply(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("preflush_count", DW'(count), 32'd3);
        advance();
        cycle(1'b1, 32'h77, 1'b1, 1'b1, 1'b1);
        apply(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("flush_count", DW'(count), 32'd0);
        check("flush_m_valid", DW'(m_valid), 32'd0);
        advance();
        cycle(1'b1, 32'h55, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check("flush_dropped_77", DW'(seen77), 32'd0);

        // Reset on the cycle a read would be issued.
        cycle(1'b1, 32'h99, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        apply(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("rst_mid_m_valid", DW'(m_valid), 32'd0);
        check("rst_mid_count", DW'(count), 32'd0);
        advance();
        cycle(1'b1, 32'h3C, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        apply(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check("post_rst_m_valid", DW'(m_valid), 32'd1);
        check("post_rst_m_data", m_data, 32'h3C);
        advance();
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
